// File: rtl/branch_pc_unit_pkg.sv
// rtl/branch_pc_unit_pkg.sv - shared constants and types for the branch/PC unit
package branch_pc_unit_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [31:0] PC_STEP = 32'd4;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

endpackage

// File: rtl/branch_pc_unit_br_cond_eval.sv
// rtl/branch_pc_unit_br_cond_eval.sv - funct3 + comparator flags to branch-condition decoder
module br_cond_eval (
   input  logic [2:0] i_funct3,
   input  logic       i_less,
   input  logic       i_equal,
   output logic       o_cond
);
   import branch_pc_unit_pkg::*;

   always_comb begin
      o_cond = 1'b0;
      case (i_funct3)
         F3_BEQ:  o_cond = i_equal;
         F3_BNE:  o_cond = !i_equal;
         F3_BLT:  o_cond = i_less;
         F3_BGE:  o_cond = !i_less;
         F3_BLTU: o_cond = i_less;
         F3_BGEU: o_cond = !i_less;
         default: o_cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - branch/jump resolution, fetch PC register and post-redirect flush
module branch_pc_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_stall,
   input  logic        i_ex_valid,
   input  logic        i_ex_is_br,
   input  logic        i_ex_is_jal,
   input  logic        i_ex_is_jalr,
   input  logic [2:0]  i_ex_funct3,
   input  logic [31:0] i_ex_pc,
   input  logic [31:0] i_ex_imm,
   input  logic [31:0] i_ex_rs1,
   input  logic        i_br_less,
   input  logic        i_br_equal,
   output logic        o_br_uns,
   output logic [31:0] o_pc,
   output logic        o_redirect,
   output logic        o_flush,
   output logic        o_misalign,
   output logic [31:0] o_br_cnt,
   output logic [31:0] o_taken_cnt
);
   import branch_pc_unit_pkg::*;

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   state_e      state_q, state_d;
   logic [2:0]  flush_cnt_q, flush_cnt_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] br_cnt_q, br_cnt_d;
   logic [31:0] taken_cnt_q, taken_cnt_d;
   logic        misalign_q, misalign_d;

   logic        cond;
   logic        considered;
   logic        is_jump;
   logic        take;
   logic        redirect;
   logic [31:0] jalr_sum;
   logic [31:0] target;

   br_cond_eval u_cond (
      .i_funct3 (i_ex_funct3),
      .i_less   (i_br_less),
      .i_equal  (i_br_equal),
      .o_cond   (cond)
   );

   // Jumps win target selection over a simultaneously flagged branch.
   always_comb begin
      considered = i_ex_valid && (state_q == ST_RUN);
      is_jump    = i_ex_is_jal || i_ex_is_jalr;
      take       = considered && (is_jump || (i_ex_is_br && cond));
      jalr_sum   = i_ex_rs1 + i_ex_imm;
      if (i_ex_is_jalr) begin
         target = jalr_sum & 32'hFFFF_FFFE;
      end else begin
         target = i_ex_pc + i_ex_imm;
      end
      redirect = take && !target[1];
   end

   always_comb begin
      pc_d        = pc_q;
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      misalign_d  = take && target[1];
      br_cnt_d    = br_cnt_q + ((considered && i_ex_is_br) ? 32'd1 : 32'd0);
      taken_cnt_d = taken_cnt_q + (redirect ? 32'd1 : 32'd0);

      if (redirect) begin
         pc_d = target;
      end else if (!i_stall) begin
         pc_d = pc_q + PC_STEP;
      end

      // Flush countdown ignores stall so the squash window has a fixed length.
      case (state_q)
         ST_RUN: begin
            if (redirect) begin
               state_d     = ST_FLUSH;
               flush_cnt_d = FLUSH_LOAD;
            end
         end
         ST_FLUSH: begin
            if (flush_cnt_q == 3'd0) begin
               state_d = ST_RUN;
            end else begin
               flush_cnt_d = flush_cnt_q - 3'd1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pc_q        <= RESET_PC;
         state_q     <= ST_RUN;
         flush_cnt_q <= 3'd0;
         misalign_q  <= 1'b0;
         br_cnt_q    <= 32'd0;
         taken_cnt_q <= 32'd0;
      end else begin
         pc_q        <= pc_d;
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         misalign_q  <= misalign_d;
         br_cnt_q    <= br_cnt_d;
         taken_cnt_q <= taken_cnt_d;
      end
   end

   assign o_br_uns    = i_ex_funct3[1];
   assign o_pc        = pc_q;
   assign o_redirect  = redirect;
   assign o_flush     = (state_q == ST_FLUSH);
   assign o_misalign  = misalign_q;
   assign o_br_cnt    = br_cnt_q;
   assign o_taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - self-checking bench for branch_pc_unit
module tb_branch_pc_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam int          FC     = 2;

   logic        clk = 1'b0;
   logic        rst, stall, valid, is_br, is_jal, is_jalr, less, equal;
   logic [2:0]  f3;
   logic [31:0] ex_pc, imm, rs1;
   logic        br_uns, redir, flush, mis;
   logic [31:0] pc, br_cnt, tk_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   branch_pc_unit #(.RESET_PC(RST_PC), .FLUSH_CYCLES(FC)) dut (
      .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_ex_valid(valid),
      .i_ex_is_br(is_br), .i_ex_is_jal(is_jal), .i_ex_is_jalr(is_jalr),
      .i_ex_funct3(f3), .i_ex_pc(ex_pc), .i_ex_imm(imm), .i_ex_rs1(rs1),
      .i_br_less(less), .i_br_equal(equal), .o_br_uns(br_uns), .o_pc(pc),
      .o_redirect(redir), .o_flush(flush), .o_misalign(mis),
      .o_br_cnt(br_cnt), .o_taken_cnt(tk_cnt)
   );

   typedef struct {
      logic        stall, valid, is_br, jal, jalr;
      logic [2:0]  f3;
      logic [31:0] pc, imm, rs1;
      logic        less, equal;
      logic        e_redir, e_uns;
      logic [31:0] e_pc;
      logic        e_mis;
      logic [31:0] e_br, e_tk;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; valid = 0; is_br = 0; is_jal = 0; is_jalr = 0;
      f3 = 3'd0; ex_pc = 0; imm = 0; rs1 = 0; less = 0; equal = 0;
   endtask

   task automatic jal_to(input logic [31:0] t);
      idle();
      valid = 1; is_jal = 1; ex_pc = 32'h0; imm = t;
   endtask

   function automatic logic ref_cond(input logic [2:0] c, input logic lt, input logic eq);
      if (c == 3'd0) return eq;
      if (c == 3'd1) return !eq;
      if (c == 3'd4 || c == 3'd6) return lt;
      if (c == 3'd5 || c == 3'd7) return !lt;
      return 1'b0;
   endfunction

   logic [31:0] m_pc, m_br, m_tk, m_tgt;
   logic        m_mis, m_take, m_redir, m_cons;
   int          m_flush_left;

   initial begin
      //            stall v br jal jalr f3    pc          imm          rs1        lt eq  red uns npc         mis br tk
      vecs[0]  = '{0,1,1,0,0,3'b000,32'h200,32'h40,32'h0,   0,1, 1,0,32'h240, 0,1,1};
      vecs[1]  = '{0,1,1,0,0,3'b000,32'h200,32'h40,32'h0,   0,0, 0,0,32'h104, 0,1,0};
      vecs[2]  = '{0,1,1,0,0,3'b001,32'h200,32'h40,32'h0,   1,0, 1,0,32'h240, 0,1,1};
      vecs[3]  = '{0,1,1,0,0,3'b100,32'h200,32'h40,32'h0,   1,0, 1,0,32'h240, 0,1,1};
      vecs[4]  = '{0,1,1,0,0,3'b101,32'h200,32'h40,32'h0,   1,0, 0,0,32'h104, 0,1,0};
      vecs[5]  = '{0,1,1,0,0,3'b110,32'h200,32'h40,32'h0,   0,0, 0,1,32'h104, 0,1,0};
      vecs[6]  = '{0,1,1,0,0,3'b111,32'h200,32'h40,32'h0,   0,0, 1,1,32'h240, 0,1,1};
      vecs[7]  = '{0,1,1,0,0,3'b010,32'h200,32'h40,32'h0,   1,1, 0,1,32'h104, 0,1,0};
      vecs[8]  = '{0,1,0,0,1,3'b000,32'h0,  32'h3, 32'h1001,0,0, 1,0,32'h1004,0,0,1};
      vecs[9]  = '{0,1,0,0,1,3'b000,32'h0,  32'h1, 32'h1001,0,0, 0,0,32'h104, 1,0,0};
      vecs[10] = '{1,1,0,1,0,3'b000,32'h80, 32'h280,32'h0,  0,0, 1,0,32'h300, 0,0,1};
      vecs[11] = '{0,0,1,0,0,3'b000,32'h200,32'h40,32'h0,   0,1, 0,0,32'h104, 0,0,0};
      vecs[12] = '{1,0,0,0,0,3'b000,32'h0,  32'h0, 32'h0,   0,0, 0,0,32'h100, 0,0,0};
      vecs[13] = '{0,1,1,0,0,3'b000,32'h200,32'h42,32'h0,   0,1, 0,0,32'h104, 1,1,0};
      vecs[14] = '{0,1,1,1,0,3'b000,32'h200,32'h40,32'h0,   0,0, 1,0,32'h240, 0,1,1};

      idle();
      rst = 1;
      step();
      step();
      chk("rst_pc", pc, RST_PC);
      chk("rst_flush", {31'd0, flush}, 0);
      chk("rst_mis", {31'd0, mis}, 0);
      chk("rst_br_cnt", br_cnt, 0);
      chk("rst_tk_cnt", tk_cnt, 0);
      rst = 0;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk($sformatf("idle_pc%0d", i), pc, RST_PC + 32'(4 * i));
         chk($sformatf("idle_flush%0d", i), {31'd0, flush}, 0);
      end

      for (int i = 0; i < 15; i++) begin
         idle();
         rst = 1;
         step();
         rst = 0;
         stall = vecs[i].stall; valid = vecs[i].valid; is_br = vecs[i].is_br;
         is_jal = vecs[i].jal; is_jalr = vecs[i].jalr; f3 = vecs[i].f3;
         ex_pc = vecs[i].pc; imm = vecs[i].imm; rs1 = vecs[i].rs1;
         less = vecs[i].less; equal = vecs[i].equal;
         #4;
         chk($sformatf("v%0d_redirect", i), {31'd0, redir}, {31'd0, vecs[i].e_redir});
         chk($sformatf("v%0d_br_uns", i), {31'd0, br_uns}, {31'd0, vecs[i].e_uns});
         step();
         idle();
         chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
         chk($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].e_redir});
         chk($sformatf("v%0d_mis", i), {31'd0, mis}, {31'd0, vecs[i].e_mis});
         chk($sformatf("v%0d_br_cnt", i), br_cnt, vecs[i].e_br);
         chk($sformatf("v%0d_tk_cnt", i), tk_cnt, vecs[i].e_tk);
      end

      // Redirect, flush window of FC cycles, JAL during flush ignored
      idle();
      rst = 1;
      step();
      rst = 0;
      valid = 1; is_br = 1; f3 = 3'b000; ex_pc = 32'h200; imm = 32'h40; equal = 1;
      step();
      chk("seqb_pc0", pc, 32'h240);
      chk("seqb_flush0", {31'd0, flush}, 1);
      jal_to(32'h800);
      #4;
      chk("seqb_jal_in_flush", {31'd0, redir}, 0);
      step();
      chk("seqb_pc1", pc, 32'h244);
      chk("seqb_flush1", {31'd0, flush}, 1);
      idle();
      step();
      chk("seqb_flush2", {31'd0, flush}, 0);
      chk("seqb_pc2", pc, 32'h248);
      chk("seqb_br_cnt", br_cnt, 1);
      chk("seqb_tk_cnt", tk_cnt, 1);

      // Redirect beats stall; stall alone holds PC while flush still expires
      jal_to(32'h300);
      stall = 1;
      step();
      chk("seqc_pc0", pc, 32'h300);
      idle();
      stall = 1;
      step();
      chk("seqc_pc1", pc, 32'h300);
      chk("seqc_flush1", {31'd0, flush}, 1);
      step();
      chk("seqc_pc2", pc, 32'h300);
      chk("seqc_flush2", {31'd0, flush}, 0);

      // Reset in first flush cycle aborts the flush
      jal_to(32'h500);
      step();
      chk("seqd_flush0", {31'd0, flush}, 1);
      idle();
      rst = 1;
      step();
      rst = 0;
      chk("seqd_pc", pc, RST_PC);
      chk("seqd_flush", {31'd0, flush}, 0);
      chk("seqd_tk_cnt", tk_cnt, 0);
      chk("seqd_br_cnt", br_cnt, 0);
      jal_to(32'h400);
      #4;
      chk("seqd_run_redirect", {31'd0, redir}, 1);
      step();
      chk("seqd_pc_after", pc, 32'h400);

      // Randomized run against a reference model
      idle();
      rst = 1;
      step();
      m_pc = RST_PC; m_br = 0; m_tk = 0; m_mis = 0; m_flush_left = 0;
      for (int n = 0; n < 3000; n++) begin
         rst     = ($urandom_range(0, 99) == 0);
         stall   = ($urandom_range(0, 3) == 0);
         valid   = ($urandom_range(0, 3) != 0);
         is_br   = $urandom_range(0, 1) == 1;
         is_jal  = ($urandom_range(0, 7) == 0);
         is_jalr = ($urandom_range(0, 7) == 0);
         f3      = 3'($urandom_range(0, 7));
         ex_pc   = $urandom & 32'hFFFF_FFFC;
         imm     = 32'($urandom_range(0, 4095)) - 32'd2048;
         rs1     = $urandom;
         less    = $urandom_range(0, 1) == 1;
         equal   = $urandom_range(0, 1) == 1;
         #4;
         m_cons  = valid && (m_flush_left == 0);
         m_tgt   = is_jalr ? ((rs1 + imm) / 2) * 2 : ex_pc + imm;
         m_take  = m_cons && (is_jal || is_jalr || (is_br && ref_cond(f3, less, equal)));
         m_redir = m_take && (m_tgt[1] == 1'b0);
         chk($sformatf("r%0d_redirect", n), {31'd0, redir}, {31'd0, m_redir});
         chk($sformatf("r%0d_br_uns", n), {31'd0, br_uns}, {29'd0, f3} >> 1 & 1);
         if (rst) begin
            m_pc = RST_PC; m_br = 0; m_tk = 0; m_mis = 0; m_flush_left = 0;
         end else begin
            m_mis = m_take && m_tgt[1];
            if (m_cons && is_br) m_br = m_br + 1;
            if (m_redir) begin
               m_tk = m_tk + 1;
               m_pc = m_tgt;
               m_flush_left = FC;
            end else begin
               if (!stall) m_pc = m_pc + 4;
               if (m_flush_left > 0) m_flush_left--;
            end
         end
         step();
         chk($sformatf("r%0d_pc", n), pc, m_pc);
         chk($sformatf("r%0d_flush", n), {31'd0, flush}, {31'd0, m_flush_left > 0});
         chk($sformatf("r%0d_mis", n), {31'd0, mis}, {31'd0, m_mis});
         chk($sformatf("r%0d_br_cnt", n), br_cnt, m_br);
         chk($sformatf("r%0d_tk_cnt", n), tk_cnt, m_tk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Stage directly downstream of the branch comparator. Consumes its less/equal flags with the EX-stage control bits and decides branch/jump outcome.
- Owns the fetch PC register, uses static predict-not-taken, and redirects the PC on a taken branch or jump.
- Drives a multi-cycle flush of younger pipeline stages after each redirect.
- Drives the comparator's unsigned-select input back from funct3 and keeps branch/taken performance counters.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC value loaded on reset.
- FLUSH_CYCLES, 2, cycles o_flush stays high after a redirect; legal range 1..7.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_stall  in  1  hazard stall; holds the PC when no redirect is pending.
- i_ex_valid  in  1  EX-stage instruction is valid.
- i_ex_is_br  in  1  EX instruction is a conditional branch.
- i_ex_is_jal  in  1  EX instruction is JAL.
- i_ex_is_jalr  in  1  EX instruction is JALR.
- i_ex_funct3  in  3  branch funct3.
- i_ex_pc  in  32  PC of the EX instruction.
- i_ex_imm  in  32  sign-extended immediate.
- i_ex_rs1  in  32  rs1 operand (JALR base).
- i_br_less  in  1  comparator less flag.
- i_br_equal  in  1  comparator equal flag.
- o_br_uns  out  1  unsigned-compare select to the comparator.
- o_pc  out  32  current fetch PC (registered).
- o_redirect  out  1  redirect taken this cycle (combinational).
- o_flush  out  1  squash IF/ID and ID/EX.
- o_misalign  out  1  one-cycle pulse: taken target not word-aligned.
- o_br_cnt  out  32  count of valid conditional branches resolved.
- o_taken_cnt  out  32  count of redirects performed.

Behaviour:
- Reset (i_reset high at a rising edge):
  - o_pc=RESET_PC, state=RUN, flush counter=0.
  - o_flush=0, o_misalign=0, both counters=0.
  - Reset has priority over every other event. Reset mid-flush aborts the flush; o_flush is low the next cycle.
- o_br_uns = i_ex_funct3[1] (combinational, always driven). This yields unsigned compares for 110/111.
- Branch condition by funct3:
  - 000 BEQ: taken if equal.
  - 001 BNE: taken if not equal.
  - 100 BLT: taken if less.
  - 101 BGE: taken if not less.
  - 110 BLTU: taken if less.
  - 111 BGEU: taken if not less.
  - 010/011: never taken.
- An instruction is considered (eligible) only when i_ex_valid=1 and state=RUN.
- take = (considered and i_ex_is_br and branch condition true) or (considered and (i_ex_is_jal or i_ex_is_jalr)).
- Target computation, modulo 2^32:
  - JALR: (i_ex_rs1 + i_ex_imm) with bit0 cleared.
  - Branch and JAL: i_ex_pc + i_ex_imm.
- Misalignment: take with target[1]=1 → o_misalign pulses next cycle, no redirect, o_taken_cnt unchanged, PC behaves as non-redirect.
- o_redirect = take and not target[1]. It is combinational in the same cycle.
- PC update each clock, in priority order:
  1. Reset.
  2. o_redirect → o_pc = target. Redirect overrides i_stall.
  3. i_stall → hold.
  4. Otherwise o_pc + 4.
- FSM states: RUN, FLUSH.
  - RUN→FLUSH on o_redirect; counter loaded with FLUSH_CYCLES-1.
  - In FLUSH, the counter decrements every cycle regardless of i_stall.
  - FLUSH→RUN when counter=0 at a clock edge.
- o_flush is high iff state=FLUSH. It is therefore high for exactly FLUSH_CYCLES cycles, starting the cycle after the redirect.
- In FLUSH, EX inputs are ignored: no redirect, no count update, no misalign pulse.
- Counters:
  - o_br_cnt increments on each considered i_ex_is_br, including misaligned ones.
  - o_taken_cnt increments on each o_redirect.
  - Both wrap at 2^32 with no saturation.
- Simultaneous flags:
  - is_jal/is_jalr take precedence over is_br for target selection.
  - Only is_br affects o_br_cnt.

Decomposition:
- Shared package: funct3 constants (F3_BEQ..F3_BGEU), state enum {RUN, FLUSH}, PC_STEP=4.
- One natural sub-module: br_cond_eval, a combinational funct3+flags→cond decoder reused by the verification model.
- PC register, FSM and counters remain in the top module.

Test Plan:
- Reset with RESET_PC=32'h100, then 3 cycles idle → o_pc 100,104,108,10C. o_flush=0, counters=0.
- BEQ at ex_pc=32'h200, imm=32'h40, equal=1 → o_redirect=1 same cycle. Next o_pc=32'h240. o_flush high exactly 2 cycles. o_br_cnt=1, o_taken_cnt=1.
- BLTU funct3=110, less=0 → o_br_uns=1, no redirect, PC+4, o_br_cnt increments, o_taken_cnt unchanged. Also: a second valid JAL presented during the FLUSH window → ignored.
- JALR with rs1=32'h1001, imm=32'h3 → target 32'h1004, redirect. A second JALR with rs1=32'h1001, imm=32'h1 → target 32'h1002 → o_misalign pulse, no redirect, PC+4.
- i_stall=1 together with a taken JAL to 32'h300 → o_pc=32'h300 next cycle. Then i_stall=1 alone → o_pc held while the flush counter still expires on schedule.
- Assert i_reset during the first FLUSH cycle → next cycle o_pc=RESET_PC, o_flush=0, counters=0, state RUN.
